// File: rtl/memory_loader_pkg.sv
// ---------------------------------------------------------------------------
// memory_loader_pkg
//   Shared definitions for the memory loader: FSM state encoding, default
//   widths and a small helper that classifies states that own the bus.
// ---------------------------------------------------------------------------
package memory_loader_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_LD_WAIT  = 3'd2,
    S_LD_WRITE = 3'd3,
    S_RD_READ  = 3'd4,
    S_RD_HOLD  = 3'd5,
    S_FIN      = 3'd6
  } state_t;

  // A job owns (or is asking for) the bus in every state except IDLE and FIN.
  function automatic logic is_busy_state(input state_t s);
    return (s != S_IDLE) && (s != S_FIN);
  endfunction

endpackage

// File: rtl/memory_loader_addr_counter.sv
// ---------------------------------------------------------------------------
// memory_loader_addr_counter
//   Address / remaining-length bookkeeping for one loader job.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     i_load       capture i_base / i_len (job start)
//     i_base       first memory address of the job
//     i_len        number of bytes in the job (0 .. 2^ADDR_W)
//     i_advance    one byte transferred: address +1 (wrapping), count -1
//     o_addr       current memory address
//     o_last       exactly one byte remains (count == 1 before advance)
// ---------------------------------------------------------------------------
module memory_loader_addr_counter #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_addr  <= i_base;
      r_count <= i_len;
    end else if (i_advance) begin
      // Address wraps naturally modulo 2^ADDR_W (255 -> 0).
      r_addr  <= r_addr + ADDR_W'(1);
      r_count <= r_count - LEN_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_count == LEN_W'(1));

endmodule

// File: rtl/memory_loader.sv
// ---------------------------------------------------------------------------
// memory_loader
//   Bus-master initiator for the shared 8-bit memory bus. After a start it
//   requests the bus from the CPU and either streams host bytes into
//   consecutive memory locations (load) or reads them back to the host (dump).
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     start_load, start_dump     one-cycle job requests (load wins if both)
//     base_addr, length          job start address and byte count (0..256)
//     in_data/in_valid/in_ready  host -> memory byte stream
//     out_data/out_valid/out_ready memory -> host byte stream
//     bus_req, bus_grant         bus ownership handshake with the CPU
//     mem_address, mem_ie, mem_oe memory control (write on negedge, comb read)
//     bus                        shared tristate data bus
//     busy, done, abort          job status (abort sticky until next start)
// ---------------------------------------------------------------------------
module memory_loader
  import memory_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_ie,
  output logic              mem_oe,
  inout  wire  [DATA_W-1:0] bus,
  output logic              busy,
  output logic              done,
  output logic              abort
);

  localparam int LEN_W = ADDR_W + 1;

  state_t            r_state;
  logic              r_is_load;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_out_data;
  logic              r_abort;

  logic              w_start;
  logic              w_load_cnt;
  logic              w_advance;
  logic              w_last;
  logic              w_busy;
  logic              w_bus_en;
  logic [ADDR_W-1:0] w_addr;

  assign w_start    = start_load | start_dump;
  assign w_load_cnt = (r_state == S_IDLE) && w_start;
  // A write always consumes its slot (even when the grant drops in that very
  // cycle); a read byte only advances once the host has taken it.
  assign w_advance  = (r_state == S_LD_WRITE) ||
                      ((r_state == S_RD_HOLD) && out_ready && bus_grant);

  memory_loader_addr_counter #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load_cnt),
    .i_base    (base_addr),
    .i_len     (length),
    .i_advance (w_advance),
    .o_addr    (w_addr),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_is_load  <= 1'b0;
      r_wr_data  <= '0;
      r_out_data <= '0;
      r_abort    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_is_load <= start_load;
            r_abort   <= 1'b0;
            r_state   <= (length == '0) ? S_FIN : S_REQ;
          end
        end
        S_REQ: begin
          if (bus_grant) r_state <= r_is_load ? S_LD_WAIT : S_RD_READ;
        end
        S_LD_WAIT: begin
          if (!bus_grant) begin
            r_abort <= 1'b1;
            r_state <= S_FIN;
          end else if (in_valid) begin
            r_wr_data <= in_data;
            r_state   <= S_LD_WRITE;
          end
        end
        S_LD_WRITE: begin
          // The strobe for this byte already happened at the mid-cycle negedge.
          if (!bus_grant) begin
            r_abort <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_state <= w_last ? S_FIN : S_LD_WAIT;
          end
        end
        S_RD_READ: begin
          if (!bus_grant) begin
            r_abort <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_out_data <= bus;
            r_state    <= S_RD_HOLD;
          end
        end
        S_RD_HOLD: begin
          if (!bus_grant) begin
            r_abort <= 1'b1;
            r_state <= S_FIN;
          end else if (out_ready) begin
            r_state <= w_last ? S_FIN : S_RD_READ;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: strobes are pure decodes of the state flop, so they cannot glitch,
  // are mutually exclusive, and drop the instant the async reset hits.
  assign w_busy    = is_busy_state(r_state);
  assign w_bus_en  = (r_state == S_LD_WRITE);
  assign mem_ie    = (r_state == S_LD_WRITE);
  assign mem_oe    = (r_state == S_RD_READ);
  assign in_ready  = (r_state == S_LD_WAIT);
  assign out_valid = (r_state == S_RD_HOLD);
  assign done      = (r_state == S_FIN);
  assign busy      = w_busy;
  assign bus_req   = w_busy;
  assign abort     = r_abort;
  assign out_data  = r_out_data;

  assign mem_address = w_busy ? w_addr : '0;
  assign bus         = w_bus_en ? r_wr_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_memory_loader.sv
module tb_memory_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_load, start_dump;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        bus_req;
  logic        bus_grant;
  logic [7:0]  mem_address;
  logic        mem_ie, mem_oe;
  wire  [7:0]  bus;
  logic        busy, done, abort;

  logic [7:0]  mem [256];
  int n_checks = 0;
  int n_fail   = 0;
  int ie_cnt = 0, oe_cnt = 0, req_cnt = 0, done_cnt = 0;
  int z_err = 0, excl_err = 0;

  always #5 clk = ~clk;

  memory_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_load  (start_load),
    .start_dump  (start_dump),
    .base_addr   (base_addr),
    .length      (length),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .bus_req     (bus_req),
    .bus_grant   (bus_grant),
    .mem_address (mem_address),
    .mem_ie      (mem_ie),
    .mem_oe      (mem_oe),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .abort       (abort)
  );

  // Undriven bus floats high, so "Z" reads back as 8'hFF.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus[g]);
  end

  // Memory responder model: combinational read, write on negedge.
  assign bus = mem_oe ? mem[mem_address] : 8'hzz;

  always @(negedge clk) begin
    if (mem_ie) begin
      mem[mem_address] = bus;
      ie_cnt++;
    end
    if (mem_oe) oe_cnt++;
    if (bus_req) req_cnt++;
    if (done) done_cnt++;
    if (mem_ie && mem_oe) excl_err++;
    if (!mem_ie && !mem_oe && bus !== 8'hFF) z_err++;
    if (mem_oe && bus !== mem[mem_address]) z_err++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input bit ld, input bit dp, input logic [7:0] base, input int len);
    base_addr  = base;
    length     = 9'(len);
    start_load = ld;
    start_dump = dp;
    tick();
    start_load = 1'b0;
    start_dump = 1'b0;
  endtask

  task automatic grant_after_req(input string name);
    int c;
    c = 0;
    while (!bus_req && c < 20) begin tick(); c++; end
    check({name, "_req_seen"}, 32'(bus_req), 1);
    repeat (2) tick();
    bus_grant = 1'b1;
  endtask

  task automatic run_load(input string name, input logic [7:0] base, input int len,
                          input logic [31:0] data, input int drop_after, input bit with_dump);
    int  idx, wr;
    bit  fin, acc, drop_pending;
    start_job(1'b1, with_dump, base, len);
    grant_after_req(name);
    idx = 0; wr = 0; fin = 0; drop_pending = 0;
    in_valid = 1'b1;
    in_data  = data[7:0];
    for (int c = 0; c < 200 && !fin; c++) begin
      acc = in_ready && in_valid;
      tick();
      if (drop_pending) begin bus_grant = 1'b0; drop_pending = 0; end
      if (acc) begin
        idx++;
        if (idx < len && idx < 4) in_data = data[8*idx +: 8];
        else in_valid = 1'b0;
      end
      if (mem_ie) begin
        wr++;
        if (wr == drop_after) drop_pending = 1;
      end
      if (done) fin = 1;
    end
    check({name, "_finished"}, 32'(fin), 1);
    check({name, "_busy_req_at_done"}, {30'd0, busy, bus_req}, 0);
    in_valid  = 1'b0;
    bus_grant = 1'b0;
    tick();
    check({name, "_done_single"}, 32'(done), 0);
  endtask

  task automatic run_dump(input string name, input logic [7:0] base, input int len,
                          output logic [31:0] got, output int n, output int stab_err);
    bit         fin, take, hold;
    logic [7:0] held;
    got = '0; n = 0; stab_err = 0; fin = 0;
    start_job(1'b0, 1'b1, base, len);
    grant_after_req(name);
    out_ready = 1'b1;
    for (int c = 0; c < 200 && !fin; c++) begin
      take = out_valid && out_ready;
      if (take && n < 4) begin got[8*n +: 8] = out_data; n++; end
      hold = out_valid && !out_ready;
      held = out_data;
      tick();
      if (hold && (!out_valid || out_data !== held)) stab_err++;
      out_ready = ~out_ready;
      if (done) fin = 1;
    end
    check({name, "_finished"}, 32'(fin), 1);
    check({name, "_busy_req_at_done"}, {30'd0, busy, bus_req}, 0);
    out_ready = 1'b0;
    bus_grant = 1'b0;
    tick();
    check({name, "_done_single"}, 32'(done), 0);
  endtask

  typedef struct {
    bit          is_load;
    logic [7:0]  base;
    int          len;
    logic [31:0] data;   // byte i at [8*i +: 8]; loaded bytes or expected dump bytes
  } job_t;

  initial begin
    job_t        jobs [4];
    logic [31:0] got;
    logic [7:0]  a;
    int          n, stab, ie0, oe0, d0, req0;

    jobs[0] = '{1'b1, 8'h10, 3, 32'h00FF5AA5};
    jobs[1] = '{1'b0, 8'h10, 3, 32'h00FF5AA5};
    jobs[2] = '{1'b1, 8'hFE, 4, 32'h04030201};
    jobs[3] = '{1'b0, 8'hFE, 4, 32'h04030201};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; start_load = 0; start_dump = 0; base_addr = 0; length = 0;
    in_data = 0; in_valid = 0; out_ready = 0; bus_grant = 0;

    #2;
    check("reset_flags", {24'd0, in_ready, out_valid, bus_req, mem_ie, mem_oe, busy, done, abort}, 0);
    check("reset_data_addr", {16'd0, out_data, mem_address}, 0);
    check("reset_bus_z", 32'(bus), 32'hFF);
    #10 rst_n = 1'b1;
    tick();

    // Table-driven load/dump jobs.
    for (int j = 0; j < 4; j++) begin
      ie0 = ie_cnt; oe0 = oe_cnt; d0 = done_cnt;
      if (jobs[j].is_load) begin
        run_load($sformatf("job%0d", j), jobs[j].base, jobs[j].len, jobs[j].data, 0, 1'b0);
        for (int i = 0; i < jobs[j].len; i++) begin
          a = jobs[j].base + 8'(i);
          check($sformatf("job%0d_mem%0d", j, i), 32'(mem[a]), 32'(jobs[j].data[8*i +: 8]));
        end
        a = jobs[j].base + 8'(jobs[j].len);
        check($sformatf("job%0d_neighbor", j), 32'(mem[a]), 0);
        check($sformatf("job%0d_ie_pulses", j), ie_cnt - ie0, jobs[j].len);
        check($sformatf("job%0d_no_oe", j), oe_cnt - oe0, 0);
      end else begin
        run_dump($sformatf("job%0d", j), jobs[j].base, jobs[j].len, got, n, stab);
        check($sformatf("job%0d_nbytes", j), n, jobs[j].len);
        for (int i = 0; i < jobs[j].len; i++)
          check($sformatf("job%0d_byte%0d", j, i), 32'(got[8*i +: 8]), 32'(jobs[j].data[8*i +: 8]));
        check($sformatf("job%0d_hold_stable", j), stab, 0);
        check($sformatf("job%0d_oe_pulses", j), oe_cnt - oe0, jobs[j].len);
        check($sformatf("job%0d_no_ie", j), ie_cnt - ie0, 0);
      end
      check($sformatf("job%0d_done_pulses", j), done_cnt - d0, 1);
      check($sformatf("job%0d_abort", j), 32'(abort), 0);
    end

    // Grant drop after the 2nd write.
    ie0 = ie_cnt; d0 = done_cnt;
    run_load("gdrop", 8'h50, 4, 32'hC4C3C2C1, 2, 1'b0);
    check("gdrop_mem50", 32'(mem[8'h50]), 32'hC1);
    check("gdrop_mem51", 32'(mem[8'h51]), 32'hC2);
    check("gdrop_mem52", 32'(mem[8'h52]), 0);
    check("gdrop_ie_pulses", ie_cnt - ie0, 2);
    check("gdrop_abort", 32'(abort), 1);
    check("gdrop_done_pulses", done_cnt - d0, 1);

    // Zero-length dump: straight to FIN, no bus request.
    req0 = req_cnt; oe0 = oe_cnt;
    start_job(1'b0, 1'b1, 8'h00, 0);
    check("len0_done", 32'(done), 1);
    check("len0_abort_cleared", 32'(abort), 0);
    tick();
    check("len0_done_single", 32'(done), 0);
    check("len0_no_req", req_cnt - req0, 0);
    check("len0_no_oe", oe_cnt - oe0, 0);

    // Async reset in the middle of an LD_WRITE cycle.
    mem[8'h30] = 8'hEE;
    ie0 = ie_cnt;
    start_job(1'b1, 1'b0, 8'h30, 4);
    grant_after_req("rst");
    in_valid = 1'b1; in_data = 8'h91;
    n = 0;
    while (!mem_ie && n < 20) begin tick(); n++; end
    check("rst_reached_write", 32'(mem_ie), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ie_req_busy", {29'd0, mem_ie, bus_req, busy}, 0);
    check("rst_bus_z", 32'(bus), 32'hFF);
    @(negedge clk); #1;
    check("rst_no_write", 32'(mem[8'h30]), 32'hEE);
    check("rst_no_ie_pulse", ie_cnt - ie0, 0);
    in_valid = 1'b0; bus_grant = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rst_idle", {30'd0, busy, done}, 0);

    // Both starts in the same cycle: the load wins.
    ie0 = ie_cnt; oe0 = oe_cnt;
    run_load("both", 8'h40, 2, 32'h00002211, 0, 1'b1);
    check("both_mem40", 32'(mem[8'h40]), 32'h11);
    check("both_mem41", 32'(mem[8'h41]), 32'h22);
    check("both_ie_pulses", ie_cnt - ie0, 2);
    check("both_no_oe", oe_cnt - oe0, 0);

    check("ie_oe_exclusive", excl_err, 0);
    check("bus_z_when_idle", z_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_loader.md
Name: memory_loader

Overview:
- Bus-master initiator for the 8-bit shared-bus memory; the counterpart to the memory responder, which only reacts to address/ie/oe.
- Requests the bus from the CPU, then does one of two jobs:
  - Load: streams bytes from a host byte interface into consecutive memory locations.
  - Dump: reads consecutive locations back out to the host.
- Sits between the host/debug port and the memory, beside the CPU control unit.

Parameters:
- ADDR_W, 8, memory address width; memory holds 2^ADDR_W bytes.
- DATA_W, 8, bus and data width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start_load  input  1  one-cycle request to start a load job.
- start_dump  input  1  one-cycle request to start a dump job.
- base_addr  input  ADDR_W  first memory address; sampled at start.
- length  input  ADDR_W+1  number of bytes, 0..256; sampled at start.
- in_data  input  DATA_W  host byte to write.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- out_data  output  DATA_W  byte read from memory.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  host accepts out_data.
- bus_req  output  1  request that the CPU release the bus.
- bus_grant  input  1  CPU has released the bus.
- mem_address  output  ADDR_W  memory address.
- mem_ie  output  1  memory write enable; memory writes on negedge clk.
- mem_oe  output  1  memory output enable; memory read is combinational.
- bus  inout  DATA_W  shared tristate bus.
- busy  output  1  a job is in progress.
- done  output  1  one-cycle pulse when a job ends.
- abort  output  1  the last job lost its grant; sticky until the next start.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; bus is Z immediately.
  - in_ready, out_valid, bus_req, mem_ie, mem_oe, busy, done = 0.
  - out_data, mem_address, internal counters = 0. abort = 0.
- States: IDLE, REQ, LD_WAIT, LD_WRITE, RD_READ, RD_HOLD, FIN.
- IDLE:
  - A start latches cur_addr=base_addr and count=length, and clears abort.
  - start_load and start_dump together: load wins.
  - length==0: go to FIN, no bus_req.
  - Otherwise go to REQ.
  - Starts are ignored in every state other than IDLE.
- bus_req=1 and busy=1 in every state except IDLE and FIN.
- REQ: wait for bus_grant=1, then go to LD_WAIT (load) or RD_READ (dump).
- LD_WAIT:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into wr_data, go to LD_WRITE.
- LD_WRITE:
  - Exactly one cycle with mem_ie=1, bus=wr_data, mem_address=cur_addr. The memory captures the byte at the mid-cycle negedge.
  - Next posedge: cur_addr+=1, count-=1. If new count==0 go to FIN, else LD_WAIT.
  - Throughput: 2 cycles per byte minimum.
- RD_READ:
  - One cycle with mem_oe=1, mem_address=cur_addr, bus not driven by the loader.
  - Posedge: out_data<=bus, go to RD_HOLD.
- RD_HOLD:
  - out_valid=1; out_data stays stable until accepted.
  - On out_ready: cur_addr+=1, count-=1. Go to FIN if count reaches 0, else RD_READ.
- FIN: done=1 for one cycle, then IDLE. bus_req drops on entry to FIN.
- Outputs mem_ie, mem_oe, in_ready, out_valid, busy and bus enable are decoded from the state register only: glitch-free and never asserted together.
- bus is driven only in LD_WRITE; Z in every other state.
- mem_address = cur_addr while busy, else 0.
- Address wrap: cur_addr increments modulo 2^ADDR_W (255 -> 0). length=256 covers all of memory exactly once.
- Grant loss: bus_grant=0 in any state after REQ aborts the job.
  - Next state FIN; abort<=1; no further ie/oe.
  - A write already in LD_WRITE still completes in that cycle.
- Reset mid-job: immediate return to the reset values above; no partial write strobe survives, because mem_ie clears asynchronously.

Decomposition:
- Shared header (global.vh): state encodings (3-bit localparams) and the LEN_W = ADDR_W+1 constant.
- One natural sub-module, loader_addr_counter:
  - Loads base/length on start.
  - Increments the address and decrements the count on an advance strobe.
  - Flags last (count==1 before advance).
- The FSM and tristate stay in the top module.

Test Plan:
- Load, length=3, base=0x10, bytes A5,5A,FF; in_valid held high; grant 2 cycles after req:
  - memory[0x10..0x12] = A5,5A,FF.
  - mem_ie high for exactly 3 single cycles.
  - done pulses once; busy falls with done.
- Dump of the same region, out_ready toggled 1/0:
  - out_data sequence A5,5A,FF.
  - Each byte held stable while out_valid=1 and out_ready=0.
  - mem_oe never coincides with mem_ie; bus is Z whenever not in LD_WRITE.
- Wrap: load, base=0xFE, length=4, bytes 1,2,3,4 -> memory[FE]=1, [FF]=2, [00]=3, [01]=4.
- length=0 with start_dump -> done one cycle later; bus_req, mem_oe never asserted.
- Grant drop: load length=4, deassert bus_grant after the 2nd write -> only 2 bytes written; abort=1; done pulses; bus_req=0 next cycle.
- Async reset mid-LD_WRITE:
  - rst_n low between edges -> mem_ie, bus_req drop immediately and bus goes Z.
  - After release, the FSM is in IDLE and a new start_load works normally.
  - Also check start_load and start_dump in the same cycle -> a load job runs.
